// File: rtl/fpmul_pkg.sv
// Shared types and helpers for the shared double-precision multiplier controller.
package fpmul_pkg;

  localparam int FP_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester tag width; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fpmul_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above the
// pointer (wrapping) wins; the result is both one-hot and encoded.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant_oh,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_any
);

  int w_best_dist;
  int w_best_idx;
  int w_dist;

  // Pick the valid requester with the smallest wrapped distance from the pointer.
  always_comb begin
    w_best_dist = NUM_REQ;
    w_best_idx  = 0;
    w_dist      = 0;
    o_any       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + NUM_REQ - int'(i_ptr));
      if (i_req[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best_idx  = i;
        o_any       = 1'b1;
      end
    end
    o_grant_idx = ID_W'(w_best_idx);
    o_grant_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_grant_oh[i] = o_any && (w_best_idx == i);
    end
  end

endmodule

// File: rtl/fpmul_share_ctrl.sv
// Shares one combinational multicycle FP64 multiplier among NUM_REQ clients:
// round-robin accept, hold operands MUL_CYCLES cycles, return tagged product.
module fpmul_share_ctrl
  import fpmul_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int MUL_CYCLES = 2,
  parameter int ID_W       = id_w(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_data,
  output logic [FP_W-1:0]         mul_a,
  output logic [FP_W-1:0]         mul_b,
  input  logic [FP_W-1:0]         mul_p,
  output logic                    busy
);

  if (MUL_CYCLES < 1) begin : g_bad_mul_cycles
    $error("fpmul_share_ctrl: MUL_CYCLES must be >= 1");
  end
  if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
    $error("fpmul_share_ctrl: NUM_REQ must be in 2..8");
  end

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_cnt;
  logic [FP_W-1:0]    r_op_a;
  logic [FP_W-1:0]    r_op_b;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [FP_W-1:0]    r_rsp_data;

  logic [NUM_REQ-1:0] w_grant_oh;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_any;
  logic               w_accept;
  logic [ID_W-1:0]    w_ptr_next;
  logic [FP_W-1:0]    w_sel_a;
  logic [FP_W-1:0]    w_sel_b;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req       (req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // Operand mux for the granted requester and the pointer that follows it.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_oh[i]) begin
        w_sel_a = req_a[i*FP_W +: FP_W];
        w_sel_b = req_b[i*FP_W +: FP_W];
      end
    end
    w_ptr_next = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : (w_grant_idx + ID_W'(1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and handshake outputs; ready is masked while reset is held.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    req_ready    = '0;
    case (r_state)
      IDLE: begin
        w_accept  = w_any && rst_n;
        req_ready = w_grant_oh & {NUM_REQ{rst_n}};
        if (w_any) w_next_state = WAIT;
      end
      WAIT: begin
        if (r_cnt == '0) w_next_state = RESP;
      end
      RESP: begin
        if (r_rsp_valid && rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture, multicycle countdown and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_id     <= w_grant_idx;
            r_rr_ptr <= w_ptr_next;
            r_cnt    <= CNT_W'(MUL_CYCLES - 1);
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_rsp_data  <= mul_p;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign mul_a     = r_op_a;
  assign mul_b     = r_op_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != IDLE);

endmodule
